// File: rtl/armbus_pkg.sv
// Shared constants and types for the ARM external bus slave.
package armbus_pkg;

   localparam int unsigned DATA_W_DEF      = 16;
   localparam int unsigned ADDR_W_DEF      = 4;
   localparam int unsigned DEPTH_DEF       = 8;
   localparam int unsigned SYNC_STAGES_DEF = 2;

   // Level of every bus strobe when the ARM side is idle (active-low strobes).
   localparam logic BUS_IDLE = 1'b1;

   // Width of the optional accepted-write counter.
   localparam int unsigned WRCNT_W = 16;

   // Bus strobes grouped so they travel through one synchroniser together.
   typedef struct packed {
      logic ce_n;
      logic we_n;
      logic oe_n;
   } strobe_t;

endpackage

// File: rtl/armbus_sync.sv
// Multi-flop synchroniser with a history flop for edge detection.
// All flops reset to the bus-idle level so no edge is seen coming out of reset.
module armbus_sync
   import armbus_pkg::*;
#(
   parameter int unsigned W      = 1,
   parameter int unsigned STAGES = SYNC_STAGES_DEF
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_level,
   output logic [W-1:0] o_rise_c,
   output logic [W-1:0] o_fall_c
);

   localparam int unsigned CHAIN_W = STAGES * W;

   logic [CHAIN_W-1:0] r_chain;
   logic [W-1:0]       r_hist;

   // Shift the pins through the synchroniser chain; oldest stage sits at the top.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_chain <= {CHAIN_W{BUS_IDLE}};
         r_hist  <= {W{BUS_IDLE}};
      end else begin
         r_chain <= {r_chain[CHAIN_W-W-1:0], i_d};
         r_hist  <= r_chain[CHAIN_W-1 -: W];
      end
   end

   assign o_level  = r_chain[CHAIN_W-1 -: W];
   assign o_rise_c = o_level & ~r_hist;
   assign o_fall_c = ~o_level & r_hist;

endmodule

// File: rtl/armbus_slave.sv
// ARM external asynchronous bus slave: DEPTH-word register file written on the
// synchronised WE rising edge, with a registered read-back path.
// Optional feature macro: ARMBUS_WRCNT_EN adds a 16-bit accepted-write counter
// readable at address DEPTH.
module armbus_slave
   import armbus_pkg::*;
#(
   parameter int unsigned DATA_W      = DATA_W_DEF,
   parameter int unsigned ADDR_W      = ADDR_W_DEF,
   parameter int unsigned DEPTH       = DEPTH_DEF,
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     bus_ce_n,
   input  logic                     bus_we_n,
   input  logic                     bus_oe_n,
   input  logic [ADDR_W-1:0]        bus_addr_i,
   input  logic [DATA_W-1:0]        bus_data_i,
   output logic [DATA_W-1:0]        bus_data_o,
   output logic                     bus_data_oe,
   output logic [DEPTH*DATA_W-1:0]  reg_q,
   output logic                     wr_pulse,
   output logic [ADDR_W-1:0]        wr_addr
);

   localparam int unsigned       IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned       STB_W   = $bits(strobe_t);
   localparam int unsigned       AD_W    = ADDR_W + DATA_W;
   localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

   strobe_t            w_stb_pins;
   strobe_t            w_stb_level;
   strobe_t            w_stb_rise_c;
   strobe_t            w_stb_fall_c;
   logic [AD_W-1:0]    w_ad_pins;
   logic [AD_W-1:0]    w_ad_level;
   logic [AD_W-1:0]    w_ad_rise_c;
   logic [AD_W-1:0]    w_ad_fall_c;
   logic [ADDR_W-1:0]  w_addr;
   logic [DATA_W-1:0]  w_data;
   logic [IDX_W-1:0]   w_idx;
   logic               w_addr_ok;
   logic               w_wr_accept;
   logic [DATA_W-1:0]  w_rd_data;
   logic               w_unused;

   logic [DEPTH-1:0][DATA_W-1:0] r_regs;
   logic [DATA_W-1:0]            r_data_o;
   logic                         r_data_oe;
   logic                         r_wr_pulse;
   logic [ADDR_W-1:0]            r_wr_addr;

   assign w_stb_pins = {bus_ce_n, bus_we_n, bus_oe_n};
   assign w_ad_pins  = {bus_addr_i, bus_data_i};

   // Strobes: synchronised levels plus WE rising edge.
   armbus_sync #(
      .W      (STB_W),
      .STAGES (SYNC_STAGES)
   ) u_sync_stb (
      .clock    (clock),
      .reset    (reset),
      .i_d      (w_stb_pins),
      .o_level  (w_stb_level),
      .o_rise_c (w_stb_rise_c),
      .o_fall_c (w_stb_fall_c)
   );

   // Address and data go through the same depth so they line up with the strobes.
   armbus_sync #(
      .W      (AD_W),
      .STAGES (SYNC_STAGES)
   ) u_sync_ad (
      .clock    (clock),
      .reset    (reset),
      .i_d      (w_ad_pins),
      .o_level  (w_ad_level),
      .o_rise_c (w_ad_rise_c),
      .o_fall_c (w_ad_fall_c)
   );

   assign w_addr      = w_ad_level[AD_W-1 -: ADDR_W];
   assign w_data      = w_ad_level[DATA_W-1:0];
   assign w_idx       = IDX_W'(w_addr);
   assign w_addr_ok   = (w_addr < DEPTH_A);
   assign w_wr_accept = w_stb_rise_c.we_n & ~w_stb_level.ce_n & w_addr_ok;

   // Only the WE rising edge is consumed; the other edge outputs are spare.
   assign w_unused = ^{w_stb_rise_c.ce_n, w_stb_rise_c.oe_n, w_stb_fall_c,
                       w_ad_rise_c, w_ad_fall_c};

`ifdef ARMBUS_WRCNT_EN
   logic [WRCNT_W-1:0] r_wrcnt;

   // Count every accepted write; wraps naturally at the counter width.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_wrcnt <= '0;
      end else if (w_wr_accept) begin
         r_wrcnt <= r_wrcnt + WRCNT_W'(1);
      end
   end
`endif

   // Register file write port and write-strobe reporting.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_regs     <= '0;
         r_wr_pulse <= 1'b0;
         r_wr_addr  <= '0;
      end else begin
         r_wr_pulse <= w_wr_accept;
         if (w_wr_accept) begin
            r_regs[w_idx] <= w_data;
            r_wr_addr     <= w_addr;
         end
      end
   end

   // Read mux: register file, optional write counter, zero elsewhere.
   always_comb begin
      w_rd_data = '0;
      if (w_addr_ok) begin
         w_rd_data = r_regs[w_idx];
      end
`ifdef ARMBUS_WRCNT_EN
      else if (w_addr == DEPTH_A) begin
         w_rd_data = DATA_W'(r_wrcnt);
      end
`endif
   end

   // Registered read data and pad enable; WE low always blocks the drive.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_data_o  <= '0;
         r_data_oe <= 1'b0;
      end else begin
         r_data_o  <= w_rd_data;
         r_data_oe <= ~w_stb_level.ce_n & ~w_stb_level.oe_n & w_stb_level.we_n;
      end
   end

   assign bus_data_o  = r_data_o;
   assign bus_data_oe = r_data_oe;
   assign reg_q       = r_regs;
   assign wr_pulse    = r_wr_pulse;
   assign wr_addr     = r_wr_addr;

endmodule

// File: tb/tb_armbus_slave.sv
// Bench for armbus_slave: pin-history reference model compared every cycle,
// directed scenarios with literal expectations, then randomised bus traffic.
module tb_armbus_slave;
   import armbus_pkg::*;

   localparam int unsigned DATA_W = DATA_W_DEF;
   localparam int unsigned ADDR_W = ADDR_W_DEF;
   localparam int unsigned DEPTH  = DEPTH_DEF;
   localparam int unsigned SYNC   = SYNC_STAGES_DEF;
   localparam int unsigned LAT    = SYNC + 1;
   localparam int unsigned QW     = DEPTH * DATA_W;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              ce_n  = 1'b1;
   logic              we_n  = 1'b1;
   logic              oe_n  = 1'b1;
   logic [ADDR_W-1:0] addr  = '1;
   logic [DATA_W-1:0] din   = '1;

   logic [DATA_W-1:0] bus_data_o;
   logic              bus_data_oe;
   logic [QW-1:0]     reg_q;
   logic              wr_pulse;
   logic [ADDR_W-1:0] wr_addr;

   always #5 clock = ~clock;

   armbus_slave #(
      .DATA_W      (DATA_W),
      .ADDR_W      (ADDR_W),
      .DEPTH       (DEPTH),
      .SYNC_STAGES (SYNC)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .bus_ce_n    (ce_n),
      .bus_we_n    (we_n),
      .bus_oe_n    (oe_n),
      .bus_addr_i  (addr),
      .bus_data_i  (din),
      .bus_data_o  (bus_data_o),
      .bus_data_oe (bus_data_oe),
      .reg_q       (reg_q),
      .wr_pulse    (wr_pulse),
      .wr_addr     (wr_addr)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int n_pulses = 0;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   // The DUT reacts, after edge m, to the pins it sampled SYNC edges earlier,
   // with the sample before that as the edge-detect reference.
   typedef struct packed {
      logic              ce_n;
      logic              we_n;
      logic              oe_n;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } pins_t;

   localparam pins_t IDLE = '1;

   pins_t             ph [SYNC+2];
   logic [DATA_W-1:0] m_mem [DEPTH];
   int unsigned       m_cnt;
   logic              m_pulse;
   logic [ADDR_W-1:0] m_wr_addr;
   logic              m_oe;
   logic [DATA_W-1:0] m_dout;

   function automatic logic [DATA_W-1:0] model_read(input int a);
      if (a < int'(DEPTH)) return m_mem[a];
`ifdef ARMBUS_WRCNT_EN
      if (a == int'(DEPTH)) return DATA_W'(m_cnt % 65536);
`endif
      return '0;
   endfunction

   function automatic logic [QW-1:0] model_q();
      logic [QW-1:0] q;
      q = '0;
      for (int k = 0; k < int'(DEPTH); k++) q[k*DATA_W +: DATA_W] = m_mem[k];
      return q;
   endfunction

   initial begin
      for (int i = 0; i < int'(SYNC) + 2; i++) ph[i] = IDLE;
      for (int k = 0; k < int'(DEPTH); k++) m_mem[k] = '0;
      m_cnt = 0; m_pulse = 0; m_wr_addr = '0; m_oe = 0; m_dout = '0;
      forever begin
         pins_t cur, prv;
         @(posedge clock);
         for (int i = int'(SYNC) + 1; i > 0; i--) ph[i] = ph[i-1];
         ph[0] = {ce_n, we_n, oe_n, addr, din};
         if (reset) begin
            for (int i = 0; i < int'(SYNC) + 2; i++) ph[i] = IDLE;
            for (int k = 0; k < int'(DEPTH); k++) m_mem[k] = '0;
            m_cnt = 0; m_pulse = 0; m_wr_addr = '0; m_oe = 0; m_dout = '0;
         end else begin
            cur     = ph[SYNC];
            prv     = ph[SYNC+1];
            m_dout  = model_read(int'(cur.addr));
            m_oe    = !cur.ce_n && !cur.oe_n && cur.we_n;
            m_pulse = 1'b0;
            if (cur.we_n && !prv.we_n && !cur.ce_n && int'(cur.addr) < int'(DEPTH)) begin
               m_mem[int'(cur.addr)] = cur.data;
               m_pulse   = 1'b1;
               m_wr_addr = cur.addr;
               m_cnt     = (m_cnt + 1) % 65536;
            end
         end
         #1;
         if (wr_pulse === 1'b1) n_pulses++;
         check("wr_pulse",    wr_pulse,    m_pulse);
         check("wr_addr",     wr_addr,     m_wr_addr);
         check("bus_data_oe", bus_data_oe, m_oe);
         check("bus_data_o",  bus_data_o,  m_dout);
         check("reg_q",       reg_q,       model_q());
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive(input logic c, input logic w, input logic o,
                        input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input int cycles);
      @(negedge clock);
      ce_n = c; we_n = w; oe_n = o; addr = a; din = d;
      repeat (cycles - 1) @(negedge clock);
   endtask

   task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      drive(1'b0, 1'b1, 1'b1, a, d, 3);
      drive(1'b0, 1'b0, 1'b1, a, d, LAT + 3);
      drive(1'b0, 1'b1, 1'b1, a, d, LAT + 3);
      drive(1'b1, 1'b1, 1'b1, a, d, 2);
   endtask

   // Bounded wait for wr_pulse (sel_oe=0) or bus_data_oe (sel_oe=1) to reach val.
   task automatic wait_sig(input bit sel_oe, input logic val, input int maxc, output int n);
      n = -1;
      for (int i = 1; i <= maxc; i++) begin
         @(posedge clock); #2;
         if ((sel_oe ? bus_data_oe : wr_pulse) === val) begin
            n = i;
            break;
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed then random ----------------
   initial begin
      int n;
      int p;
      logic [QW-1:0] e;

      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (3) @(posedge clock);
      #2;
      check("reset_reg_q", reg_q, '0);
      check("reset_oe", bus_data_oe, 1'b0);

      // Write 0xBEEF to address 3 and measure the write latency.
      drive(1'b0, 1'b1, 1'b1, 4'd3, 16'hBEEF, 3);
      drive(1'b0, 1'b0, 1'b1, 4'd3, 16'hBEEF, 6);
      @(negedge clock); we_n = 1'b1;
      wait_sig(1'b0, 1'b1, 10, n);
      check("wr_latency", n, LAT);
      check("wr_addr_3", wr_addr, 4'd3);
      e = '0; e[3*DATA_W +: DATA_W] = 16'hBEEF;
      check("reg_q_beef", reg_q, e);
      check("pulse_count_1", n_pulses, 1);
      drive(1'b0, 1'b1, 1'b1, 4'd3, 16'hBEEF, 3);
      drive(1'b1, 1'b1, 1'b1, 4'd3, 16'hBEEF, 2);

      // Write then read back address 2, measuring oe latency both ways.
      bus_write(4'd2, 16'h1234);
      @(negedge clock); ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1; addr = 4'd2;
      wait_sig(1'b1, 1'b1, 10, n);
      check("oe_rise_latency", n, LAT);
      check("read_1234", bus_data_o, 16'h1234);
      @(negedge clock); oe_n = 1'b1;
      wait_sig(1'b1, 1'b0, 10, n);
      check("oe_fall_latency", n, LAT);
      drive(1'b1, 1'b1, 1'b1, 4'd2, 16'h0, 3);

      // Out-of-range write is ignored and reads back as zero.
      p = n_pulses;
      bus_write(4'd12, 16'hAAAA);
      check("oor_no_pulse", n_pulses, p);
      e = '0; e[3*DATA_W +: DATA_W] = 16'hBEEF; e[2*DATA_W +: DATA_W] = 16'h1234;
      check("oor_regs_kept", reg_q, e);
      @(negedge clock); ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1; addr = 4'd12;
      wait_sig(1'b1, 1'b1, 10, n);
      check("oor_oe_latency", n, LAT);
      check("oor_read_zero", bus_data_o, 16'h0000);
      drive(1'b1, 1'b1, 1'b1, 4'd0, 16'h0, 3);

      // OE and WE low together: no drive until WE rises.
      @(negedge clock); ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b0; addr = 4'd1; din = 16'h5A5A;
      for (int i = 0; i < 6; i++) begin
         @(posedge clock); #2;
         check("contention_oe_low", bus_data_oe, 1'b0);
      end
      @(negedge clock); we_n = 1'b1;
      wait_sig(1'b1, 1'b1, 10, n);
      check("contention_oe_latency", n, LAT);
      @(posedge clock); #2;
      check("read_after_write", bus_data_o, 16'h5A5A);
      drive(1'b1, 1'b1, 1'b1, 4'd1, 16'h0, 3);

      // Two more writes (five accepted), then read address DEPTH.
      bus_write(4'd0, 16'h1111);
      bus_write(4'd7, 16'h7777);
      check("pulse_count_5", n_pulses, 5);
      @(negedge clock); ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1; addr = 4'd8;
      wait_sig(1'b1, 1'b1, 10, n);
`ifdef ARMBUS_WRCNT_EN
      check("wrcnt_read", bus_data_o, 16'h0005);
`else
      check("addr_depth_read", bus_data_o, 16'h0000);
`endif
      drive(1'b1, 1'b1, 1'b1, 4'd0, 16'h0, 3);

      // Reset while WE is low, WE raised at release: the edge is lost.
      drive(1'b0, 1'b0, 1'b1, 4'd4, 16'h4444, 5);
      p = n_pulses;
      @(negedge clock); reset = 1'b1;
      @(negedge clock); reset = 1'b0; we_n = 1'b1;
      repeat (8) @(posedge clock);
      #2;
      check("reset_mid_no_pulse", n_pulses, p);
      check("reset_mid_regs", reg_q, '0);
      check("reset_mid_wr_addr", wr_addr, 4'd0);
      drive(1'b1, 1'b1, 1'b1, 4'd0, 16'h0, 3);

      // Randomised traffic, including short pulses and occasional resets.
      for (int t = 0; t < 500; t++) begin
         int hold;
         hold = int'($urandom_range(1, 6));
         @(negedge clock);
         reset = ($urandom_range(0, 99) == 0);
         ce_n  = ($urandom_range(0, 3) == 0);
         we_n  = 1'($urandom_range(0, 1));
         oe_n  = 1'($urandom_range(0, 1));
         addr  = ADDR_W'($urandom_range(0, 15));
         din   = DATA_W'($urandom);
         for (int h = 1; h < hold; h++) begin
            @(negedge clock);
            reset = 1'b0;
         end
      end
      @(negedge clock);
      reset = 1'b0; ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1;
      repeat (6) @(negedge clock);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/armbus_slave.md
# armbus_slave

Parametrised slave for the ARM external asynchronous memory bus. Generalises the single 16-bit write-latch capture path to an addressed register file of DEPTH words of DATA_W bits, with a read-back path. All bus pins are synchronised and edge-detected in the `clock` domain. The block sits between the GPIO pad tristates at top level and fabric logic, such as the segment display drivers, which consume `reg_q`.

## Interface
Parameters:
- DATA_W, 16: bus data width.
- ADDR_W, 4: bus address width.
- DEPTH, 8: number of ARM-writable registers. Must satisfy DEPTH < 2^ADDR_W.
- SYNC_STAGES, 2: synchroniser flops per bus input, minimum 2.

Ports:
- clock  in  1: single system clock (PLL output).
- reset  in  1: synchronous, active-high reset.
- bus_ce_n  in  1: chip enable, active low.
- bus_we_n  in  1: write enable, active low; data is written on its rising edge.
- bus_oe_n  in  1: output enable, active low.
- bus_addr_i  in  ADDR_W: word address.
- bus_data_i  in  DATA_W: data pads, input side.
- bus_data_o  out  DATA_W: data pads, output side.
- bus_data_oe  out  1: pad drive enable; top level tristates when low.
- reg_q  out  DEPTH*DATA_W: flattened register contents; word k is at [k*DATA_W +: DATA_W].
- wr_pulse  out  1: one-cycle pulse per accepted write.
- wr_addr  out  ADDR_W: address of the last accepted write.

## Operation
- All bus inputs pass through SYNC_STAGES flops, then one history flop for edge detection. Address and data use the same depth so they stay aligned with the strobes.
- Write acceptance: synchronised `bus_we_n` goes 0→1 while synchronised `bus_ce_n` = 0 and address < DEPTH. The aligned data is stored to `reg[addr]`, `wr_pulse` = 1 and `wr_addr` = addr.
- Write to address ≥ DEPTH: ignored; no `wr_pulse`. Exception: the write-counter address when `ARMBUS_WRCNT_EN` is defined, which is still read-only, so no store and no pulse.
- Read path:
  - `bus_data_oe` = 1 while synchronised CE = 0, OE = 0 and WE = 1.
  - `bus_data_o` is registered every cycle from `reg[sync addr]`.
  - Out-of-range addresses read 0.
- Contention guard: if synchronised WE = 0, `bus_data_oe` is forced to 0 regardless of OE.
- CE high: no writes are accepted and `bus_data_oe` = 0.
- Address changes during a read: `bus_data_o` follows with the same latency as the read path.
- Reset values:
  - All registers, `bus_data_o`, `wr_addr` and the write counter = 0.
  - `bus_data_oe` = 0 and `wr_pulse` = 0.
  - Synchroniser and history flops = 1 (bus idle), so no spurious edge is seen after reset.
- Reset mid-transaction: the pending edge is lost and nothing is written.

## Timing
- Write: the sampled WE rising edge appears at the pin input → register updated and `wr_pulse` high SYNC_STAGES+1 cycles later. `reg_q` is valid in the same cycle as `wr_pulse`.
- Read: CE/OE falling → `bus_data_oe` high after SYNC_STAGES+1 cycles. Data is valid in the same cycle.
- Read-after-write to the same address: the new value appears on `bus_data_o` one cycle after `wr_pulse`.
- Minimum WE low and WE high widths: SYNC_STAGES+1 clock periods each. Shorter pulses may be missed.
- The ARM bus timing must be programmed to allow this read latency plus pad delay.

## Configuration
- `ARMBUS_WRCNT_EN` defined:
  - Adds a 16-bit counter, incremented on every accepted write and wrapping FFFF→0000.
  - Readable at address DEPTH, zero-extended or truncated to DATA_W.
- `ARMBUS_WRCNT_EN` undefined:
  - No counter logic.
  - Address DEPTH behaves as any other out-of-range address: reads 0, writes ignored.

## Structure
- Package `armbus_pkg`:
  - Default width constants.
  - Idle-level constant for bus strobes (1).
  - Write-counter width constant (16).
- Sub-module `armbus_sync`:
  - Parametrised width, SYNC_STAGES-deep synchroniser with a history flop.
  - Outputs synchronised level, rise and fall.
  - Instantiated once for the strobes and once for address+data.

## Test plan
- Reset, then CE=0 and WE pulsed low for 6 cycles at addr 3, data 0xBEEF → `wr_pulse` once, `wr_addr`=3, `reg_q` word 3 = 0xBEEF, all other words 0.
- Write 0x1234 to addr 2, then CE=0/OE=0 at addr 2 → `bus_data_oe`=1 after SYNC_STAGES+1 cycles, `bus_data_o`=0x1234. OE=1 → oe drops with the same latency.
- Write to addr 12 (DEPTH=8), then read addr 12 → no `wr_pulse`, all registers unchanged, read returns 0x0000.
- OE=0 and WE=0 simultaneously at addr 1 → `bus_data_oe` stays 0. After the WE rising edge, oe asserts.
- With `ARMBUS_WRCNT_EN`, 5 accepted writes then read addr 8 → 0x0005. Preload 0xFFFF and write once → 0x0000.
- Assert `reset` for one cycle while WE is low, release, then raise WE → no write accepted and no `wr_pulse`.
